// File: rtl/div_unit_iter.sv
// div_unit_iter -- iterative integer divide unit (DIV / DIVU / REM / REMU).
//
// Issued operations go into an in-order queue. Operand magnitudes, their
// leading-zero counts and the sign fix-up are worked out at issue. A single
// engine then pops the head and either resolves it in the pop cycle (divide
// by zero, dividend smaller than divisor, or a reuse hit) or runs a radix-2
// restoring divide. The divide starts at the divisor's aligned MSB, so it
// takes divisor_clz - dividend_clz + 1 cycles. Results wait on a
// done/ack handshake.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      drop queued/in-flight work, invalidate reuse
//   req_valid / req_ready      issue handshake (ready = queue not full)
//   req_op                     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_rs1, req_rs2           dividend, divisor
//   req_rs1_addr/_rs2_addr/_rd_addr  register addresses for the reuse cache
//   req_id                     instruction ID carried to writeback
//   wr_valid, wr_addr          a register write was issued this cycle
//   wb_done / wb_ack           writeback handshake
//   wb_id, wb_rd               ID and value of the completed op
module div_unit_iter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [4:0]       req_rs1_addr,
  input  logic [4:0]       req_rs2_addr,
  input  logic [4:0]       req_rd_addr,
  input  logic [ID_W-1:0]  req_id,
  input  logic             wr_valid,
  input  logic [4:0]       wr_addr,
  output logic             wb_done,
  input  logic             wb_ack,
  output logic [ID_W-1:0]  wb_id,
  output logic [WIDTH-1:0] wb_rd
);

  localparam int CLZ_W = $clog2(WIDTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [CLZ_W-1:0] a_clz;
    logic [CLZ_W-1:0] b_clz;
    logic             div_zero;
    logic             rem_op;
    logic             negate;
    logic             reuse;
    logic [ID_W-1:0]  id;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  // Leading-zero count; an all-zero value returns WIDTH.
  function automatic logic [CLZ_W-1:0] clz(input logic [WIDTH-1:0] v);
    logic [CLZ_W-1:0] n;
    n = CLZ_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = CLZ_W'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  // Pick quotient or remainder and apply the sign fix-up.
  function automatic logic [WIDTH-1:0] fmt(input logic rem_op, input logic neg,
                                           input logic [WIDTH-1:0] q,
                                           input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] s;
    s = rem_op ? r : q;
    return neg ? -s : s;
  endfunction

  // ---------------------------------------------------------------------
  // Issue-side preprocessing
  // ---------------------------------------------------------------------
  logic             req_signed;
  logic [WIDTH-1:0] rs1_mag, rs2_mag;
  logic             rs2_zero;
  logic             push, pop;
  logic             full, empty;
  entry_t           new_entry;

  logic             cache_valid;
  logic             cache_signed;
  logic [4:0]       cache_rs1, cache_rs2;
  logic             reuse_hit;

  assign req_signed = ~req_op[0];
  assign rs1_mag    = (req_signed & req_rs1[WIDTH-1]) ? -req_rs1 : req_rs1;
  assign rs2_mag    = (req_signed & req_rs2[WIDTH-1]) ? -req_rs2 : req_rs2;
  assign rs2_zero   = (req_rs2 == '0);

  assign reuse_hit = cache_valid && (cache_rs1 == req_rs1_addr) &&
                     (cache_rs2 == req_rs2_addr) && (cache_signed == req_signed);

  assign req_ready = ~full;
  // A request arriving in the flush cycle is dropped.
  assign push      = req_valid & req_ready & ~flush;

  always_comb begin
    new_entry.a_mag    = rs1_mag;
    new_entry.b_mag    = rs2_mag;
    new_entry.a_clz    = clz(rs1_mag);
    new_entry.b_clz    = clz(rs2_mag);
    new_entry.div_zero = rs2_zero;
    new_entry.rem_op   = req_op[1];
    new_entry.negate   = req_op[1] ? (req_signed & req_rs1[WIDTH-1])
                                   : (req_signed & (req_rs1[WIDTH-1] ^ req_rs2[WIDTH-1])
                                      & ~rs2_zero);
    new_entry.reuse    = reuse_hit;
    new_entry.id       = req_id;
  end

  // Reuse cache: the last accepted op's sources stay valid until one of them
  // is overwritten. An op that writes one of its own sources can't be reused.
  // NOTE: state registers use non-blocking (<=) so every always_ff reads the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
    end else if (push) begin
      cache_valid  <= (req_rd_addr != req_rs1_addr) && (req_rd_addr != req_rs2_addr);
      cache_signed <= req_signed;
      cache_rs1    <= req_rs1_addr;
      cache_rs2    <= req_rs2_addr;
    end else if (wr_valid && ((wr_addr == cache_rs1) || (wr_addr == cache_rs2))) begin
      cache_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // In-order queue
  // ---------------------------------------------------------------------
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array has no reset; count/pointers decide what is
  // valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Divide engine
  // ---------------------------------------------------------------------
  state_t           state;
  logic [WIDTH-1:0] quo_r, rem_r, div_r;
  logic [CLZ_W-1:0] cnt;
  logic             cur_rem_op, cur_negate;
  logic [ID_W-1:0]  cur_id;

  assign pop = ~empty & ~flush & ((state == IDLE) || ((state == DONE) && wb_ack));

  // Pop-cycle resolution. When no early case applies, early_q/early_r are
  // the starting quotient (0) and partial remainder (the dividend).
  logic             early;
  logic [WIDTH-1:0] early_q, early_r;
  logic [CLZ_W-1:0] head_shift;

  assign head_shift = head.b_clz - head.a_clz;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    early   = 1'b1;
    early_q = '0;
    early_r = head.a_mag;
    if (head.div_zero) begin
      early_q = '1;
    end else if (head.a_clz > head.b_clz) begin
      early_q = '0;
    end else if (head.reuse) begin
      early_q = quo_r;
      early_r = rem_r;
    end else begin
      early = 1'b0;
    end
  end

  // One restoring step: subtract the aligned divisor when it fits.
  logic             step_ge;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign step_ge  = (rem_r >= div_r);
  assign step_rem = step_ge ? (rem_r - div_r) : rem_r;
  assign step_quo = {quo_r[WIDTH-2:0], step_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wb_done    <= 1'b0;
      wb_id      <= '0;
      wb_rd      <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      div_r      <= '0;
      cnt        <= '0;
      cur_rem_op <= 1'b0;
      cur_negate <= 1'b0;
      cur_id     <= '0;
    end else if (flush) begin
      state   <= IDLE;
      wb_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (pop) begin
            cur_rem_op <= head.rem_op;
            cur_negate <= head.negate;
            cur_id     <= head.id;
            quo_r      <= early_q;
            rem_r      <= early_r;
            div_r      <= head.b_mag << head_shift;
            cnt        <= head_shift;
            if (early) begin
              state   <= DONE;
              wb_done <= 1'b1;
              wb_id   <= head.id;
              wb_rd   <= fmt(head.rem_op, head.negate, early_q, early_r);
            end else begin
              state   <= DIVIDE;
              wb_done <= 1'b0;
            end
          end else if ((state == DONE) && wb_ack) begin
            state   <= IDLE;
            wb_done <= 1'b0;
          end
        end

        DIVIDE: begin
          quo_r <= step_quo;
          rem_r <= step_rem;
          div_r <= div_r >> 1;
          if (cnt == '0) begin
            state   <= DONE;
            wb_done <= 1'b1;
            wb_id   <= cur_id;
            wb_rd   <= fmt(cur_rem_op, cur_negate, step_quo, step_rem);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          wb_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_iter.sv
// Testbench for div_unit_iter. Issued requests push their expected result,
// ID and latency into a scoreboard queue; each writeback pops and compares.
module tb_div_unit_iter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_rs1, req_rs2;
  logic [4:0]       req_rs1_addr, req_rs2_addr, req_rd_addr;
  logic [ID_W-1:0]  req_id;
  logic             wr_valid;
  logic [4:0]       wr_addr;
  logic             wb_done;
  logic             wb_ack;
  logic [ID_W-1:0]  wb_id;
  logic [WIDTH-1:0] wb_rd;

  div_unit_iter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rs1_addr (req_rs1_addr),
    .req_rs2_addr (req_rs2_addr),
    .req_rd_addr  (req_rd_addr),
    .req_id       (req_id),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wb_done      (wb_done),
    .wb_ack       (wb_ack),
    .wb_id        (wb_id),
    .wb_rd        (wb_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     val;
    int              lat;  // edges from accept to wb_done, -1 = unchecked
    int              acc;
  } exp_t;

  exp_t            scb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [ID_W-1:0] next_id = '0;

  // RISC-V M-extension reference result.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sd, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0]) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      sa = a;
      sd = b;
      sq = sa / sd;
      sr = sa % sd;
      q  = sq;
      r  = sr;
    end
    return op[1] ? r : q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                       input int lat);
    exp_t e;
    int   w;
    w = 0;
    while (!req_ready && w < 200) begin
      tick();
      w++;
    end
    n_tests++;
    if (!req_ready) begin
      $display("FAIL issue_ready: req_ready=%0b required 1 (timeout)", req_ready);
      n_fail++;
      return;
    end
    req_valid    = 1'b1;
    req_op       = op;
    req_rs1      = a;
    req_rs2      = b;
    req_rs1_addr = ra;
    req_rs2_addr = rb;
    req_rd_addr  = rd;
    req_id       = next_id;
    tick();
    req_valid = 1'b0;
    e.id  = next_id;
    e.val = ref_res(op, a, b);
    e.lat = lat;
    e.acc = cyc;
    scb.push_back(e);
    next_id++;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   w;
    w = 0;
    while (!wb_done && w < 200) begin
      tick();
      w++;
    end
    n_tests++;
    if (!wb_done) begin
      $display("FAIL %s_done: wb_done=0 required 1 (timeout)", name);
      n_fail++;
      return;
    end
    if (scb.size() == 0) begin
      $display("FAIL %s_unexpected: wb_done=1 with id=%0d, none required", name, wb_id);
      n_fail++;
    end else begin
      e = scb.pop_front();
      n_tests++;
      if (wb_id !== e.id) begin
        $display("FAIL %s_id: got %0d required %0d", name, wb_id, e.id);
        n_fail++;
      end
      n_tests++;
      if (wb_rd !== e.val) begin
        $display("FAIL %s_rd: got %h required %h", name, wb_rd, e.val);
        n_fail++;
      end
      if (e.lat >= 0) begin
        n_tests++;
        if (cyc - e.acc !== e.lat) begin
          $display("FAIL %s_lat: got %0d required %0d", name, cyc - e.acc, e.lat);
          n_fail++;
        end
      end
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (wb_done !== 1'b0) begin
      $display("FAIL reset_done: got %b required 0", wb_done); n_fail++;
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b required 1", req_ready); n_fail++;
    end
    n_tests++;
    if (wb_id !== '0) begin
      $display("FAIL reset_id: got %0d required 0", wb_id); n_fail++;
    end
    n_tests++;
    if (wb_rd !== '0) begin
      $display("FAIL reset_rd: got %h required 0", wb_rd); n_fail++;
    end
  endtask

  task automatic test_basic_reuse();
    issue(OP_DIV, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3, 6);
    collect("div_100_7");
    issue(OP_REM, 32'd100, 32'd7, 5'd1, 5'd2, 5'd4, 1);
    collect("rem_100_7_reuse");
  endtask

  task automatic test_signed();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 5'd6, 5'd7, 3);
    collect("div_m7_2");
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 5'd6, 5'd7, 1);
    collect("rem_m7_2");
    issue(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd5, 5'd6, 5'd7, 32);
    collect("remu_noreuse");
  endtask

  task automatic test_corner();
    issue(OP_DIVU, 32'd5, 32'd0, 5'd10, 5'd11, 5'd12, 1);
    collect("divu_by0");
    issue(OP_REM, 32'd5, 32'd0, 5'd13, 5'd14, 5'd15, 1);
    collect("rem_by0");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 5'd17, 5'd18, 33);
    collect("div_ovf");
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 5'd17, 5'd19, 1);
    collect("rem_ovf");
    issue(OP_DIVU, 32'd3, 32'd100, 5'd20, 5'd21, 5'd22, 1);
    collect("divu_small");
  endtask

  task automatic test_queue_fill();
    issue(OP_DIVU, 32'd50, 32'd5, 5'd23, 5'd24, 5'd25, -1);
    issue(OP_REM, 32'hFFFF_FFCE, 32'd7, 5'd26, 5'd27, 5'd28, -1);
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd23, 5'd27, 5'd26, -1);
    n_tests++;
    if (req_ready !== 1'b0) begin
      $display("FAIL fill_ready: got %b required 0", req_ready); n_fail++;
    end
    repeat (40) tick();
    n_tests++;
    if (wb_done !== 1'b1 || wb_id !== scb[0].id) begin
      $display("FAIL fill_hold: done=%b id=%0d required done=1 id=%0d", wb_done, wb_id,
               scb[0].id);
      n_fail++;
    end
    n_tests++;
    if (req_ready !== 1'b0) begin
      $display("FAIL fill_ready_held: got %b required 0", req_ready); n_fail++;
    end
    collect("fill0");
    collect("fill1");
    collect("fill2");
  endtask

  task automatic test_reuse_invalidate();
    issue(OP_DIV, 32'd1000, 32'd9, 5'd29, 5'd30, 5'd31, 8);
    collect("inv_div");
    wr_valid = 1'b1;
    wr_addr  = 5'd30;
    tick();
    wr_valid = 1'b0;
    issue(OP_REM, 32'd1000, 32'd9, 5'd29, 5'd30, 5'd1, 8);
    collect("inv_rem");
  endtask

  task automatic test_flush();
    int seen;
    issue(OP_DIVU, 32'h8000_0000, 32'd1, 5'd3, 5'd4, 5'd5, -1);
    issue(OP_DIVU, 32'd7, 32'd3, 5'd6, 5'd7, 5'd8, -1);
    issue(OP_DIVU, 32'd9, 32'd2, 5'd9, 5'd10, 5'd11, -1);
    repeat (5) tick();
    flush        = 1'b1;
    req_valid    = 1'b1;
    req_op       = OP_DIVU;
    req_rs1      = 32'd12;
    req_rs2      = 32'd4;
    req_rs1_addr = 5'd12;
    req_rs2_addr = 5'd13;
    req_rd_addr  = 5'd14;
    req_id       = next_id;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    scb.delete();
    n_tests++;
    if (wb_done !== 1'b0) begin
      $display("FAIL flush_done: got %b required 0", wb_done); n_fail++;
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      $display("FAIL flush_ready: got %b required 1", req_ready); n_fail++;
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wb_done) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      $display("FAIL flush_quiet: wb_done high %0d cycles required 0", seen); n_fail++;
    end
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd6, 5'd7, 5'd8, 6);
    collect("post_flush");
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_rs1_addr = '0;
    req_rs2_addr = '0;
    req_rd_addr  = '0;
    req_id    = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wb_ack    = 1'b0;
    tick();
    test_reset();
    test_basic_reuse();
    test_signed();
    test_corner();
    test_queue_fill();
    test_reuse_invalidate();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
